// File: rtl/uart_param_core.sv
// Runtime-configurable UART core: baud divisor, parity, 1/2 stop bits, TX/RX word FIFOs, sticky errors.
// Optional feature macro: UART_LOOPBACK_EN (internal tx->rx path selected by the loopback port).
module uart_param_core #(
  parameter int D_BIT    = 8,
  parameter int DVSR_BIT = 11,
  parameter int FIFO_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic [1:0]          par_mode,
  input  logic                stop2,
  input  logic                loopback,
  input  logic                wr_uart,
  input  logic [D_BIT-1:0]    w_data,
  input  logic                rd_uart,
  output logic [D_BIT-1:0]    r_data,
  output logic                tx_full,
  output logic                rx_empty,
  input  logic                rx,
  output logic                tx,
  output logic                tx_busy,
  input  logic                clr_err,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun_err
);
  localparam int DEPTH = 2**FIFO_W;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DVSR_BIT-1:0] baud_cnt, dvsr_m1;
  logic                tick;
  assign dvsr_m1 = dvsr - DVSR_BIT'(1);
  assign tick    = (dvsr != '0) && (baud_cnt == dvsr_m1);

  // A shrunk divisor below the current count wraps immediately instead of counting through the full range.
  always_ff @(posedge clk or negedge reset)
    if (!reset)                                 baud_cnt <= '0;
    else if (dvsr == '0 || baud_cnt >= dvsr_m1) baud_cnt <= '0;
    else                                        baud_cnt <= baud_cnt + DVSR_BIT'(1);

  logic [D_BIT-1:0]  tx_mem [DEPTH];
  logic [FIFO_W-1:0] txf_wp, txf_rp;
  logic [FIFO_W:0]   txf_cnt;
  logic              tx_empty, tx_push, tx_pop;
  assign tx_full  = txf_cnt == (FIFO_W+1)'(DEPTH);
  assign tx_empty = txf_cnt == '0;
  assign tx_push  = wr_uart && !tx_full;

  always_ff @(posedge clk) if (tx_push) tx_mem[txf_wp] <= w_data;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      txf_wp <= '0; txf_rp <= '0; txf_cnt <= '0;
    end else begin
      if (tx_push) txf_wp <= txf_wp + FIFO_W'(1);
      if (tx_pop)  txf_rp <= txf_rp + FIFO_W'(1);
      txf_cnt <= txf_cnt + (FIFO_W+1)'(tx_push) - (FIFO_W+1)'(tx_pop);
    end

  logic [D_BIT-1:0]  rx_mem [DEPTH];
  logic [FIFO_W-1:0] rxf_wp, rxf_rp;
  logic [FIFO_W:0]   rxf_cnt;
  logic              rx_full, rx_done, rx_push, rx_pop;
  logic [D_BIT-1:0]  rx_sh;
  assign rx_full  = rxf_cnt == (FIFO_W+1)'(DEPTH);
  assign rx_empty = rxf_cnt == '0;
  assign rx_push  = rx_done && !rx_full;
  assign rx_pop   = rd_uart && !rx_empty;
  assign r_data   = rx_mem[rxf_rp];

  always_ff @(posedge clk) if (rx_push) rx_mem[rxf_wp] <= rx_sh;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rxf_wp <= '0; rxf_rp <= '0; rxf_cnt <= '0;
    end else begin
      if (rx_push) rxf_wp <= rxf_wp + FIFO_W'(1);
      if (rx_pop)  rxf_rp <= rxf_rp + FIFO_W'(1);
      rxf_cnt <= rxf_cnt + (FIFO_W+1)'(rx_push) - (FIFO_W+1)'(rx_pop);
    end

  logic rx_src, rx_q1, rx_s;
`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx : rx;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign rx_src = rx;
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_q1 <= 1'b1; rx_s <= 1'b1;
    end else begin
      rx_q1 <= rx_src; rx_s <= rx_q1;
    end

  state_t           tx_state, tx_state_n;
  logic [4:0]       tx_tc, tx_tc_n;
  logic [2:0]       tx_bc, tx_bc_n;
  logic [D_BIT-1:0] tx_sh, tx_sh_n;
  logic             tx_pen, tx_pen_n, tx_pbit, tx_pbit_n, tx_stop2, tx_stop2_n;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_state <= IDLE; tx_tc <= '0; tx_bc <= '0; tx_sh <= '0;
      tx_pen <= 1'b0; tx_pbit <= 1'b0; tx_stop2 <= 1'b0;
    end else begin
      tx_state <= tx_state_n; tx_tc <= tx_tc_n; tx_bc <= tx_bc_n; tx_sh <= tx_sh_n;
      tx_pen <= tx_pen_n; tx_pbit <= tx_pbit_n; tx_stop2 <= tx_stop2_n;
    end

  // Leaving IDLE is aligned to a tick so every bit, including the start bit, lasts exactly 16 ticks.
  always_comb begin
    tx_state_n = tx_state; tx_tc_n = tx_tc; tx_bc_n = tx_bc; tx_sh_n = tx_sh;
    tx_pen_n = tx_pen; tx_pbit_n = tx_pbit; tx_stop2_n = tx_stop2;
    tx_pop = 1'b0;
    if (tick) begin
      case (tx_state)
        IDLE:   tx_pop = !tx_empty;
        START:  if (tx_tc == 5'd15) begin
                  tx_state_n = DATA; tx_tc_n = '0; tx_bc_n = '0;
                end else tx_tc_n = tx_tc + 5'd1;
        DATA:   if (tx_tc == 5'd15) begin
                  tx_tc_n = '0;
                  tx_sh_n = tx_sh >> 1;
                  if (tx_bc == 3'(D_BIT-1)) tx_state_n = tx_pen ? PARITY : STOP;
                  else                      tx_bc_n = tx_bc + 3'd1;
                end else tx_tc_n = tx_tc + 5'd1;
        PARITY: if (tx_tc == 5'd15) begin
                  tx_state_n = STOP; tx_tc_n = '0;
                end else tx_tc_n = tx_tc + 5'd1;
        STOP:   if (tx_tc == (tx_stop2 ? 5'd31 : 5'd15)) begin
                  tx_state_n = IDLE; tx_tc_n = '0; tx_pop = !tx_empty;
                end else tx_tc_n = tx_tc + 5'd1;
        default: tx_state_n = IDLE;
      endcase
      if (tx_pop) begin
        tx_state_n = START; tx_tc_n = '0;
        tx_sh_n    = tx_mem[txf_rp];
        tx_pen_n   = par_mode[0] ^ par_mode[1];
        tx_pbit_n  = (^tx_mem[txf_rp]) ^ (par_mode == 2'b10);
        tx_stop2_n = stop2;
      end
    end
  end

  always_comb begin
    tx      = 1'b1;
    tx_busy = tx_state != IDLE;
    case (tx_state)
      START:   tx = 1'b0;
      DATA:    tx = tx_sh[0];
      PARITY:  tx = tx_pbit;
      default: tx = 1'b1;
    endcase
  end

  state_t           rx_state, rx_state_n;
  logic [4:0]       rx_tc, rx_tc_n;
  logic [2:0]       rx_bc, rx_bc_n;
  logic [D_BIT-1:0] rx_sh_n;
  logic             rx_pen, rx_pen_n, rx_podd, rx_podd_n, rx_stop2, rx_stop2_n;
  logic             rx_pbad, rx_pbad_n, rx_fbad, rx_fbad_n, rx_ferr_now;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_state <= IDLE; rx_tc <= '0; rx_bc <= '0; rx_sh <= '0;
      rx_pen <= 1'b0; rx_podd <= 1'b0; rx_stop2 <= 1'b0; rx_pbad <= 1'b0; rx_fbad <= 1'b0;
    end else begin
      rx_state <= rx_state_n; rx_tc <= rx_tc_n; rx_bc <= rx_bc_n; rx_sh <= rx_sh_n;
      rx_pen <= rx_pen_n; rx_podd <= rx_podd_n; rx_stop2 <= rx_stop2_n;
      rx_pbad <= rx_pbad_n; rx_fbad <= rx_fbad_n;
    end

  // Start bit is confirmed at its midpoint; every later bit is sampled 16 ticks after the previous one.
  always_comb begin
    rx_state_n = rx_state; rx_tc_n = rx_tc; rx_bc_n = rx_bc; rx_sh_n = rx_sh;
    rx_pen_n = rx_pen; rx_podd_n = rx_podd; rx_stop2_n = rx_stop2;
    rx_pbad_n = rx_pbad; rx_fbad_n = rx_fbad;
    if (tick) begin
      case (rx_state)
        IDLE:   if (!rx_s) begin
                  rx_state_n = START; rx_tc_n = '0;
                end
        START:  if (rx_tc == 5'd7) begin
                  if (rx_s) rx_state_n = IDLE;
                  else begin
                    rx_state_n = DATA; rx_tc_n = '0; rx_bc_n = '0;
                    rx_pen_n   = par_mode[0] ^ par_mode[1];
                    rx_podd_n  = par_mode == 2'b10;
                    rx_stop2_n = stop2;
                    rx_pbad_n  = 1'b0; rx_fbad_n = 1'b0;
                  end
                end else rx_tc_n = rx_tc + 5'd1;
        DATA:   if (rx_tc == 5'd15) begin
                  rx_tc_n = '0;
                  rx_sh_n = {rx_s, rx_sh[D_BIT-1:1]};
                  if (rx_bc == 3'(D_BIT-1)) rx_state_n = rx_pen ? PARITY : STOP;
                  else                      rx_bc_n = rx_bc + 3'd1;
                end else rx_tc_n = rx_tc + 5'd1;
        PARITY: if (rx_tc == 5'd15) begin
                  rx_pbad_n  = ((^rx_sh) ^ rx_s) != rx_podd;
                  rx_state_n = STOP; rx_tc_n = '0;
                end else rx_tc_n = rx_tc + 5'd1;
        STOP:   if (rx_tc == (rx_stop2 ? 5'd31 : 5'd15)) begin
                  rx_state_n = IDLE; rx_tc_n = '0;
                end else begin
                  if (rx_tc == 5'd15) rx_fbad_n = !rx_s;
                  rx_tc_n = rx_tc + 5'd1;
                end
        default: rx_state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_done     = 1'b0;
    rx_ferr_now = 1'b0;
    if (tick && rx_state == STOP && rx_tc == (rx_stop2 ? 5'd31 : 5'd15)) begin
      rx_done     = 1'b1;
      rx_ferr_now = rx_stop2 ? rx_fbad : !rx_s;
    end
  end

  // Setting wins over a simultaneous clear so no error event is lost.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      parity_err <= 1'b0; frame_err <= 1'b0; overrun_err <= 1'b0;
    end else begin
      if (rx_done && rx_pbad)       parity_err <= 1'b1;
      else if (clr_err)             parity_err <= 1'b0;
      if (rx_done && rx_ferr_now)   frame_err <= 1'b1;
      else if (clr_err)             frame_err <= 1'b0;
      if (rx_done && rx_full)       overrun_err <= 1'b1;
      else if (clr_err)             overrun_err <= 1'b0;
    end
endmodule
